// File: rtl/parking_gate_ctrl_if.sv
// Sensor, card-reader, space-flag and event signals between the field,
// the gate controller and the Parking occupancy block.
interface parking_gate_ctrl_if;
  logic ent_arrive;
  logic ext_arrive;
  logic ent_pass;
  logic ext_pass;
  logic ent_uni;
  logic ext_uni;
  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic ent_barrier_up;
  logic ext_barrier_up;
  logic ent_full;
  logic car_entered;
  logic car_exited;
  logic is_uni_car_entered;
  logic is_uni_car_exited;
  logic timeout;

  modport master (
    output ent_arrive, ext_arrive, ent_pass, ext_pass, ent_uni, ext_uni,
           uni_is_vacated_space, is_vacated_space,
    input  ent_barrier_up, ext_barrier_up, ent_full, car_entered, car_exited,
           is_uni_car_entered, is_uni_car_exited, timeout
  );

  modport slave (
    input  ent_arrive, ext_arrive, ent_pass, ext_pass, ent_uni, ext_uni,
           uni_is_vacated_space, is_vacated_space,
    output ent_barrier_up, ext_barrier_up, ent_full, car_entered, car_exited,
           is_uni_car_entered, is_uni_car_exited, timeout
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Entrance/exit barrier controller: sensor debouncing, two lane FSMs and an
// event arbiter producing one car_entered/car_exited pulse per passing car.
module pgc_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
endmodule

// state   | meaning
// IDLE    | barrier down, waiting for a car on the arrive loop
// GRANT   | one cycle: latch card flag, decide open or refuse
// REFUSED | entrance only: category full, lamp on until car leaves
// OPEN    | barrier up, waiting for the pass loop or the timeout
// PASSING | car under the barrier, no timeout
// HOLD    | barrier down for CLOSE_HOLD, then wait for arrive to clear
module pgc_lane #(
  parameter bit IS_ENTRY     = 1'b1,
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_arrive,
  input  logic i_pass,
  input  logic i_uni,
  input  logic i_uni_space,
  input  logic i_space,
  output logic o_barrier_up,
  output logic o_full,
  output logic o_req,
  output logic o_uni,
  output logic o_timeout
);
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_REFUSED, S_OPEN, S_PASSING, S_HOLD
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic       r_req;
  logic       r_uni;
  logic       r_timeout;
  logic       w_allowed;
  logic       w_open_expired;
  logic       w_hold_done;

  assign w_allowed      = i_uni ? i_uni_space : i_space;
  assign w_open_expired = (r_cnt == 8'(OPEN_TIMEOUT));
  assign w_hold_done    = (r_cnt >= 8'(CLOSE_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_arrive) w_next = S_GRANT;
      S_GRANT:   w_next = (!IS_ENTRY || w_allowed) ? S_OPEN : S_REFUSED;
      S_REFUSED: if (!i_arrive) w_next = S_IDLE;
      S_OPEN: begin
        if (i_pass)              w_next = S_PASSING;
        else if (w_open_expired) w_next = S_HOLD;
      end
      S_PASSING: if (!i_pass) w_next = S_HOLD;
      S_HOLD:    if (w_hold_done && !i_arrive) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counter restarts on every state change; it saturates so a car parked
  // on the arrive loop in HOLD never wraps it back below CLOSE_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 8'd0;
      r_req     <= 1'b0;
      r_uni     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != w_next)  r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      r_req     <= (r_state == S_PASSING) && !i_pass;
      r_timeout <= (r_state == S_OPEN) && !i_pass && w_open_expired;
      if (r_state == S_GRANT) r_uni <= i_uni;
    end
  end

  always_comb begin
    o_barrier_up = 1'b0;
    o_full       = 1'b0;
    case (r_state)
      S_OPEN, S_PASSING: o_barrier_up = 1'b1;
      S_REFUSED:         o_full       = IS_ENTRY;
      default:           ;
    endcase
  end

  assign o_req     = r_req;
  assign o_uni     = r_uni;
  assign o_timeout = r_timeout;
endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 8
) (
  input logic               clk,
  input logic               start,
  parking_gate_ctrl_if.slave bus
);
  logic w_ent_arrive, w_ent_pass, w_ext_arrive, w_ext_pass;
  logic w_ent_req, w_ent_uni, w_ent_to;
  logic w_ext_req, w_ext_uni, w_ext_to;
  logic w_ent_act;
  logic r_ent_pend;
  logic r_car_entered, r_car_exited;
  logic r_uni_entered, r_uni_exited;

  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ent_arrive (
    .clk(clk), .rst_n(start), .i_raw(bus.ent_arrive), .o_level(w_ent_arrive));
  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ent_pass (
    .clk(clk), .rst_n(start), .i_raw(bus.ent_pass), .o_level(w_ent_pass));
  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ext_arrive (
    .clk(clk), .rst_n(start), .i_raw(bus.ext_arrive), .o_level(w_ext_arrive));
  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ext_pass (
    .clk(clk), .rst_n(start), .i_raw(bus.ext_pass), .o_level(w_ext_pass));

  pgc_lane #(.IS_ENTRY(1'b1), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)) u_ent (
    .clk(clk), .rst_n(start), .i_arrive(w_ent_arrive), .i_pass(w_ent_pass),
    .i_uni(bus.ent_uni), .i_uni_space(bus.uni_is_vacated_space),
    .i_space(bus.is_vacated_space), .o_barrier_up(bus.ent_barrier_up),
    .o_full(bus.ent_full), .o_req(w_ent_req), .o_uni(w_ent_uni), .o_timeout(w_ent_to));

  logic w_ext_full_unused;
  pgc_lane #(.IS_ENTRY(1'b0), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)) u_ext (
    .clk(clk), .rst_n(start), .i_arrive(w_ext_arrive), .i_pass(w_ext_pass),
    .i_uni(bus.ext_uni), .i_uni_space(bus.uni_is_vacated_space),
    .i_space(bus.is_vacated_space), .o_barrier_up(bus.ext_barrier_up),
    .o_full(w_ext_full_unused), .o_req(w_ext_req), .o_uni(w_ext_uni), .o_timeout(w_ext_to));

  // Exit wins a collision; the entry event is parked for one cycle. A lane
  // cannot request again within CLOSE_HOLD, so one pending slot suffices.
  assign w_ent_act = w_ent_req | r_ent_pend;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_ent_pend    <= 1'b0;
      r_car_entered <= 1'b0;
      r_car_exited  <= 1'b0;
      r_uni_entered <= 1'b0;
      r_uni_exited  <= 1'b0;
    end else begin
      r_car_exited  <= w_ext_req;
      r_car_entered <= w_ent_act && !w_ext_req;
      r_ent_pend    <= w_ent_act && w_ext_req;
      if (w_ext_req)               r_uni_exited  <= w_ext_uni;
      if (w_ent_act && !w_ext_req) r_uni_entered <= w_ent_uni;
    end
  end

  assign bus.car_entered        = r_car_entered;
  assign bus.car_exited         = r_car_exited;
  assign bus.is_uni_car_entered = r_uni_entered;
  assign bus.is_uni_car_exited  = r_uni_exited;
  assign bus.timeout            = w_ent_to | w_ext_to;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: vector table of single-car
// scenarios plus hand sequences for timing, collisions, stationary car, reset.
module tb_parking_gate_ctrl;
  localparam int DEB = 4;
  localparam int OT  = 20;
  localparam int CH  = 4;

  logic clk   = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  parking_gate_ctrl_if bus();

  parking_gate_ctrl #(.DEBOUNCE(DEB), .OPEN_TIMEOUT(OT), .CLOSE_HOLD(CH)) dut (
    .clk(clk), .start(start), .bus(bus.slave));

  typedef struct {
    bit is_exit;
    bit uni;
  } ev_t;

  typedef struct {
    bit lane_exit;
    bit uni;
    bit uni_space;
    bit space;
    bit do_pass;
    bit exp_open;
    bit exp_full;
    int exp_events;
    int exp_to;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[8];

  int checks   = 0;
  int failures = 0;
  int n_ent = 0, n_ext = 0, n_to = 0;
  int up_ent = 0, up_ext = 0;
  bit seen_ent_up = 0, seen_ext_up = 0, seen_full = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input bit is_exit, input bit uni);
    ev_t ev;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got event exit=%0d uni=%0d expected none", is_exit, uni);
    end else begin
      ev = sb_q.pop_front();
      chk("sb_lane", int'(is_exit), int'(ev.is_exit));
      chk("sb_uni", int'(uni), int'(ev.uni));
    end
  endtask

  task automatic sb_push(input bit is_exit, input bit uni);
    ev_t ev;
    ev.is_exit = is_exit;
    ev.uni     = uni;
    sb_q.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (start) begin
      if (bus.ent_barrier_up) begin seen_ent_up = 1; up_ent++; end
      if (bus.ext_barrier_up) begin seen_ext_up = 1; up_ext++; end
      if (bus.ent_full) seen_full = 1;
      if (bus.timeout) n_to++;
      if (bus.car_entered || bus.car_exited) begin
        chk("pulse_exclusive", int'(bus.car_entered & bus.car_exited), 0);
        if (bus.car_exited)  begin n_ext++; sb_pop(1'b1, bus.is_uni_car_exited); end
        if (bus.car_entered) begin n_ent++; sb_pop(1'b0, bus.is_uni_car_entered); end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.ent_barrier_up, bus.ext_barrier_up, bus.ent_full, bus.car_entered,
            bus.car_exited, bus.is_uni_car_entered, bus.is_uni_car_exited, bus.timeout};
  endfunction

  task automatic set_arrive(input bit lane_exit, input bit v);
    if (lane_exit) bus.ext_arrive = v; else bus.ent_arrive = v;
  endtask

  task automatic set_pass(input bit lane_exit, input bit v);
    if (lane_exit) bus.ext_pass = v; else bus.ent_pass = v;
  endtask

  task automatic clear_obs();
    seen_ent_up = 0; seen_ext_up = 0; seen_full = 0; up_ent = 0; up_ext = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int e0, t0;
    bus.uni_is_vacated_space = v.uni_space;
    bus.is_vacated_space     = v.space;
    if (v.lane_exit) bus.ext_uni = v.uni; else bus.ent_uni = v.uni;
    clear_obs();
    e0 = v.lane_exit ? n_ext : n_ent;
    t0 = n_to;
    set_arrive(v.lane_exit, 1'b1);
    step(12);
    if (v.do_pass) begin
      set_pass(v.lane_exit, 1'b1);
      set_arrive(v.lane_exit, 1'b0);
      step(10);
      set_pass(v.lane_exit, 1'b0);
      if (v.exp_events > 0) sb_push(v.lane_exit, v.uni);
      step(30);
    end else begin
      step(30);
      set_arrive(v.lane_exit, 1'b0);
      step(30);
    end
    chk($sformatf("v%0d_opened", idx), int'(v.lane_exit ? seen_ext_up : seen_ent_up), int'(v.exp_open));
    chk($sformatf("v%0d_full", idx), int'(seen_full), int'(v.exp_full));
    chk($sformatf("v%0d_events", idx), (v.lane_exit ? n_ext : n_ent) - e0, v.exp_events);
    chk($sformatf("v%0d_timeouts", idx), n_to - t0, v.exp_to);
    if (v.exp_to != 0)
      chk($sformatf("v%0d_up_cycles", idx), v.lane_exit ? up_ext : up_ent, OT + 1);
    chk($sformatf("v%0d_full_clear", idx), int'(bus.ent_full), 0);
  endtask

  initial begin
    int e0, x0, t0;
    //         exit uni uspc spc pass open full ev to
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};

    bus.ent_arrive = 0; bus.ext_arrive = 0; bus.ent_pass = 0; bus.ext_pass = 0;
    bus.ent_uni = 0; bus.ext_uni = 0; bus.uni_is_vacated_space = 0; bus.is_vacated_space = 0;
    step(3);
    chk("reset_outputs", int'(outs()), 0);
    start = 1'b1;
    step(5);
    chk("post_reset_outputs", int'(outs()), 0);

    // Visitor entry: exact barrier and event timing, space flag ignored once open
    bus.is_vacated_space = 1; bus.ent_uni = 0;
    e0 = n_ent;
    bus.ent_arrive = 1;
    step(7);
    chk("t1_barrier_n7", int'(bus.ent_barrier_up), 0);
    step(1);
    chk("t1_barrier_n8", int'(bus.ent_barrier_up), 1);
    bus.is_vacated_space = 0;
    step(2);
    bus.ent_pass = 1; bus.ent_arrive = 0;
    step(10);
    chk("t1_barrier_held_after_flag_drop", int'(bus.ent_barrier_up), 1);
    bus.ent_pass = 0;
    sb_push(1'b0, 1'b0);
    step(7);
    chk("t1_barrier_down_m1", int'(bus.ent_barrier_up), 0);
    chk("t1_no_pulse_yet", int'(bus.car_entered), 0);
    step(1);
    chk("t1_pulse_m2", int'(bus.car_entered), 1);
    chk("t1_pulse_uni", int'(bus.is_uni_car_entered), 0);
    step(1);
    chk("t1_pulse_single", int'(bus.car_entered), 0);
    step(30);
    chk("t1_event_count", n_ent - e0, 1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Glitch rejection
    clear_obs();
    bus.is_vacated_space = 1;
    bus.ent_arrive = 1;
    step(3);
    bus.ent_arrive = 0;
    step(20);
    chk("glitch_no_barrier", int'(seen_ent_up), 0);
    chk("glitch_no_full", int'(seen_full), 0);

    // Simultaneous pass-out on both lanes
    bus.is_vacated_space = 1; bus.ent_uni = 0; bus.ext_uni = 1;
    bus.ent_arrive = 1; bus.ext_arrive = 1;
    step(12);
    bus.ent_pass = 1; bus.ext_pass = 1; bus.ent_arrive = 0; bus.ext_arrive = 0;
    step(10);
    bus.ent_pass = 0; bus.ext_pass = 0;
    sb_push(1'b1, 1'b1);
    sb_push(1'b0, 1'b0);
    step(7);
    chk("sim_none_m1", int'({bus.car_exited, bus.car_entered}), 0);
    step(1);
    chk("sim_exit_first", int'({bus.car_exited, bus.car_entered}), 2);
    chk("sim_exit_uni", int'(bus.is_uni_car_exited), 1);
    step(1);
    chk("sim_entry_next", int'({bus.car_exited, bus.car_entered}), 1);
    chk("sim_entry_uni", int'(bus.is_uni_car_entered), 0);
    step(30);
    bus.ext_uni = 0;

    // Stationary car on the exit arrive loop
    x0 = n_ext;
    bus.ext_arrive = 1;
    step(12);
    bus.ext_pass = 1;
    step(10);
    bus.ext_pass = 0;
    sb_push(1'b1, 1'b0);
    step(40);
    chk("stat_one_event", n_ext - x0, 1);
    clear_obs();
    step(20);
    chk("stat_no_reopen", int'(seen_ext_up), 0);
    bus.ext_arrive = 0;
    step(12);
    bus.ext_arrive = 1;
    step(12);
    chk("stat_reopen", int'(bus.ext_barrier_up), 1);
    bus.ext_pass = 1; bus.ext_arrive = 0;
    step(10);
    bus.ext_pass = 0;
    sb_push(1'b1, 1'b0);
    step(30);
    chk("stat_second_event", n_ext - x0, 2);

    // Reset while a car is under the entrance barrier
    e0 = n_ent; t0 = n_to;
    bus.is_vacated_space = 1;
    bus.ent_arrive = 1;
    step(12);
    bus.ent_pass = 1; bus.ent_arrive = 0;
    step(10);
    chk("rst_pre_barrier", int'(bus.ent_barrier_up), 1);
    start = 1'b0;
    #1;
    chk("rst_outputs_immediate", int'(outs()), 0);
    bus.ent_pass = 0;
    step(3);
    start = 1'b1;
    step(30);
    chk("rst_no_event", n_ent - e0, 0);
    chk("rst_no_timeout", n_to - t0, 0);
    run_vec(8, vecs[0]);

    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Lane controller that drives the event inputs of the `Parking` occupancy block. Debounces raw loop sensors at the entrance and exit barriers, opens a barrier only when the car is allowed through, and emits exactly one `car_entered`/`car_exited` pulse per car that fully passes. Each pulse carries a university/visitor flag. It sits between the field sensors and `Parking`, and reads back `Parking`'s space-available flags to refuse entry when the matching category is full.

## Interface
- `DEBOUNCE`, 4: cycles a synchronized sensor level must be stable before the debounced level changes (≥1).
- `OPEN_TIMEOUT`, 200: cycles the barrier stays up waiting for the pass sensor (≤255).
- `CLOSE_HOLD`, 8: cycles a lane stays blocked after the barrier closes (≤255).

Ports:
- `clk` in 1: single clock.
- `start` in 1: reset, asynchronous, active-low; 0 = held in reset.
- `ent_arrive`, `ext_arrive` in 1: raw loop sensor in front of the entrance/exit barrier.
- `ent_pass`, `ext_pass` in 1: raw loop sensor behind the barrier.
- `ent_uni`, `ext_uni` in 1: card-reader flag, 1 = university car; sampled in GRANT.
- `uni_is_vacated_space`, `is_vacated_space` in 1: from `Parking`; university/visitor space available.
- `ent_barrier_up`, `ext_barrier_up` out 1: barrier open command.
- `ent_full` out 1: entry refused lamp.
- `car_entered`, `car_exited` out 1: single-cycle event pulses to `Parking`.
- `is_uni_car_entered`, `is_uni_car_exited` out 1: category of the last pulse; valid with the pulse and held until the next one.
- `timeout` out 1: single-cycle pulse when either lane times out.

## Operation
- **Sensors.** Each raw sensor passes through a 2-flop synchronizer, then a debounce counter. The debounced level flips after `DEBOUNCE` consecutive synchronized cycles differing from it. Glitches shorter than that are ignored.
- **Lane FSMs.** There are two independent lane FSMs with identical states except REFUSED, which is entrance only.
  - IDLE: barrier down; debounced arrive = 1 → GRANT.
  - GRANT (1 cycle): latch `*_uni`.
    - Exit lane always → OPEN.
    - Entrance → OPEN if (uni ? `uni_is_vacated_space` : `is_vacated_space`), else → REFUSED.
  - REFUSED: `ent_full` = 1, barrier down; debounced arrive = 0 → IDLE.
  - OPEN: barrier up; an 8-bit counter runs.
    - Debounced pass = 1 → PASSING.
    - Counter reaches `OPEN_TIMEOUT` → `timeout` pulse, barrier down, → HOLD, no event.
  - PASSING: barrier up, no timeout while the car is under the barrier. Debounced pass = 0 → request event, barrier down, → HOLD.
  - HOLD: barrier down for `CLOSE_HOLD` cycles, then wait for debounced arrive = 0 → IDLE. A stationary car never re-triggers.
- **Event arbiter.**
  - An event request asserts the lane's pulse plus its category output in the next cycle.
  - If both lanes request in the same cycle, `car_exited` fires first and `car_entered` fires the following cycle. Both pulses are never high together, and no event is lost.
  - At most one pending event per lane; a lane cannot request again within `CLOSE_HOLD` ≥1 cycles.
- **Timeout.** `timeout` is the OR of both lanes' timeout pulses.
- **Reset.** `start` = 0 at any time forces IDLE, clears counters and synchronizers, and drops all outputs to 0 immediately (barriers down). Pending events are discarded.

## Timing
- Reset value of every output: 0.
- Raw arrive rises at edge N and is held stable → debounced high at N+`DEBOUNCE`+2 → GRANT at N+`DEBOUNCE`+3 → `*_barrier_up` = 1 from N+`DEBOUNCE`+4.
- Debounced pass falls at edge M → barrier down at M+1 → event pulse at M+2 (M+3 if deferred by the arbiter).
- Timeout: barrier drops `OPEN_TIMEOUT`+1 cycles after entering OPEN, with the `timeout` pulse in the same cycle.
- Space flags are sampled only in GRANT. A flag change while a car is in OPEN/PASSING does not close the barrier.

## Test plan
(DEBOUNCE=4, OPEN_TIMEOUT=20, CLOSE_HOLD=4)
1. **Visitor entry.** Release `start`; visitor at entrance with `is_vacated_space`=1; hold `ent_arrive`, then pulse `ent_pass` for 10 cycles. Required: barrier up 8 cycles after the arrive edge; exactly one `car_entered` with `is_uni_car_entered`=0, 2 cycles after debounced pass falls.
2. **Refused university car.** `ent_uni`=1, `uni_is_vacated_space`=0. Required: `ent_full`=1 and barrier never up; `ent_full` returns to 0 after arrive drops; no pulse.
3. **Glitch rejection and timeout.** A 3-cycle `ent_arrive` glitch must produce no barrier. A full arrival with no pass must give barrier up for 21 cycles, one `timeout` pulse, and no `car_entered`.
4. **Simultaneous requests.** Align entrance and exit passes so both request in the same cycle. Required: `car_exited` (uni=1) fires in cycle K and `car_entered` (uni=0) in K+1, never both high together.
5. **Stationary car.** Car stays on `ext_arrive` after exiting. Required: exactly one `car_exited`, and no re-open until arrive drops and rises again.
6. **Reset mid-passage.** `start`=0 while in PASSING. Required: all outputs 0 within the same cycle and no event pulse; after release, the next full car yields exactly one pulse.
